// File: rtl/riscv_pkg.sv
// riscv_pkg: shared memory-arbiter grant states and default bus widths
package riscv_pkg;
  localparam int ADDR_W = 64;
  localparam int LINE_W = 128;
  typedef enum logic [1:0] {GNT_IDLE, GNT_IC, GNT_DC} mem_gnt_e;
endpackage

// File: rtl/riscv_mem_wdog.sv
// riscv_mem_wdog: grant watchdog, counts stalled cycles and pulses once on reaching TIMEOUT
module riscv_mem_wdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : (inc && cnt_q != CW'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
    timeout = !clr && inc && cnt_q == CW'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin share of the main-memory port between icache and dcache
module riscv_mem_arbiter import riscv_pkg::*; #(
  parameter int ADDR_W  = riscv_pkg::ADDR_W,
  parameter int LINE_W  = riscv_pkg::LINE_W,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_mem_rden,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic              ic_mem_ready,
  output logic [LINE_W-1:0] ic_mem_rdata,
  input  logic              dc_mem_rden,
  input  logic              dc_mem_wren,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [LINE_W-1:0] dc_mem_wdata,
  output logic              dc_mem_ready,
  output logic [LINE_W-1:0] dc_mem_rdata,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              mem_timeout
);
  mem_gnt_e state_q, state_d;
  logic last_dc_q, last_dc_d;
  logic ic_req, dc_req, gnt_ic, gnt_dc;
  always_comb begin
    ic_req = ic_mem_rden;
    dc_req = dc_mem_rden | dc_mem_wren;
    gnt_ic = state_q == GNT_IC;
    gnt_dc = state_q == GNT_DC;
    last_dc_d = gnt_dc ? 1'b1 : gnt_ic ? 1'b0 : last_dc_q;
    state_d = state_q;
    case (state_q)
      GNT_IDLE: state_d = (dc_req && (!ic_req || !last_dc_q)) ? GNT_DC : ic_req ? GNT_IC : GNT_IDLE;
      GNT_IC:   state_d = (mem_ready || !ic_req) ? GNT_IDLE : GNT_IC;
      // write-back completion holds the grant so the following allocate is atomic
      GNT_DC:   state_d = mem_ready ? (dc_mem_wren ? GNT_DC : GNT_IDLE) : dc_req ? GNT_DC : GNT_IDLE;
      default:  state_d = GNT_IDLE;
    endcase
    mem_rden     = gnt_ic ? ic_mem_rden : gnt_dc ? dc_mem_rden : 1'b0;
    mem_wren     = gnt_dc & dc_mem_wren;
    mem_addr     = gnt_ic ? ic_mem_addr : gnt_dc ? dc_mem_addr : '0;
    mem_wdata    = gnt_dc ? dc_mem_wdata : '0;
    ic_mem_ready = gnt_ic & mem_ready;
    dc_mem_ready = gnt_dc & mem_ready;
    ic_mem_rdata = mem_rdata;
    dc_mem_rdata = mem_rdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GNT_IDLE;
      last_dc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_dc_q <= last_dc_d;
    end
  end
  riscv_mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (!(gnt_ic || gnt_dc) || mem_ready),
    .inc     ((gnt_ic || gnt_dc) && !mem_ready),
    .timeout (mem_timeout)
  );
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed stimulus, per-cycle owner model plus literal spot checks
module tb_riscv_mem_arbiter;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic ic_rden = 0, dc_rden = 0, dc_wren = 0, mem_ready = 0;
  logic [63:0] ic_addr = '0, dc_addr = '0, mem_addr;
  logic [127:0] dc_wdata = '0, mem_rdata = '0, mem_wdata, ic_rdata, dc_rdata;
  logic ic_ready, dc_ready, mem_rden, mem_wren, mem_timeout;
  int vecs = 0, errs = 0;
  int own = 0, waited = 0;
  bit last_dc = 0;

  riscv_mem_arbiter #(.ADDR_W(64), .LINE_W(128), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ic_mem_rden(ic_rden), .ic_mem_addr(ic_addr), .ic_mem_ready(ic_ready), .ic_mem_rdata(ic_rdata),
    .dc_mem_rden(dc_rden), .dc_mem_wren(dc_wren), .dc_mem_addr(dc_addr), .dc_mem_wdata(dc_wdata),
    .dc_mem_ready(dc_ready), .dc_mem_rdata(dc_rdata),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // owner: 0 nobody, 1 icache, 2 dcache; waited counts grant cycles without ready
  always @(negedge clk) begin
    logic drq;
    drq = dc_rden | dc_wren;
    chk("m_rden", mem_rden, !rst && (own == 1 ? ic_rden : own == 2 ? dc_rden : 1'b0));
    chk("m_wren", mem_wren, !rst && own == 2 && dc_wren);
    chk("m_addr", mem_addr, rst ? 64'd0 : own == 1 ? ic_addr : own == 2 ? dc_addr : 64'd0);
    chk("m_wdata", mem_wdata, (!rst && own == 2) ? dc_wdata : 128'd0);
    chk("m_icready", ic_ready, !rst && own == 1 && mem_ready);
    chk("m_dcready", dc_ready, !rst && own == 2 && mem_ready);
    chk("m_timeout", mem_timeout, !rst && own != 0 && !mem_ready && waited + 1 == TO);
    chk("m_rdata", ic_rdata ^ dc_rdata ^ mem_rdata, mem_rdata);
    if (rst) begin
      own = 0; last_dc = 0; waited = 0;
    end else if (own == 0) begin
      waited = 0;
      own = (ic_rden && drq) ? (last_dc ? 1 : 2) : ic_rden ? 1 : drq ? 2 : 0;
    end else begin
      last_dc = own == 2;
      waited = mem_ready ? 0 : (waited < TO ? waited + 1 : waited);
      if (mem_ready) own = (own == 2 && dc_wren) ? 2 : 0;
      else if (own == 1 ? !ic_rden : !drq) own = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    tick(); tick(); look();
    chk("reset_rden", mem_rden, 0);
    chk("reset_addr", mem_addr, 0);
    tick(); rst = 0;
    // single icache fill
    tick(); ic_rden = 1; ic_addr = 64'h1000; look();
    chk("s1_idle", mem_rden, 0);
    tick(); look();
    chk("s1_rden", mem_rden, 1);
    chk("s1_addr", mem_addr, 64'h1000);
    tick(); tick(); mem_ready = 1; mem_rdata = 128'hdead_beef_0123; look();
    chk("s1_icready", ic_ready, 1);
    chk("s1_dcready", dc_ready, 0);
    tick(); mem_ready = 0; ic_rden = 0; look();
    chk("s1_back_idle", mem_rden, 0);
    // round-robin ties
    tick(); ic_rden = 1; dc_rden = 1; ic_addr = 64'h3000; dc_addr = 64'h4000; look();
    tick(); look();
    chk("s2_dc_first", mem_addr, 64'h4000);
    tick(); mem_ready = 1; mem_rdata = 128'h55aa; look();
    chk("s2_dcready", dc_ready, 1);
    chk("s2_icready", ic_ready, 0);
    tick(); mem_ready = 0; dc_rden = 0; look();
    tick(); look();
    chk("s2_ic_next", mem_addr, 64'h3000);
    tick(); mem_ready = 1; look();
    tick(); mem_ready = 0; dc_rden = 1; look();
    tick(); look();
    chk("s2_dc_again", mem_addr, 64'h4000);
    tick(); mem_ready = 1; look();
    tick(); mem_ready = 0; ic_rden = 0; dc_rden = 0; look();
    // locked write-back then allocate, icache waiting
    tick(); dc_wren = 1; dc_addr = 64'h2000; dc_wdata = 128'hcafe_f00d; look();
    tick(); ic_rden = 1; ic_addr = 64'h1040; look();
    chk("s3_wren", mem_wren, 1);
    chk("s3_wdata", mem_wdata, 128'hcafe_f00d);
    tick(); mem_ready = 1; look();
    chk("s3_wb_ready", dc_ready, 1);
    tick(); mem_ready = 0; dc_wren = 0; dc_rden = 1; look();
    chk("s3_lock_rden", mem_rden, 1);
    chk("s3_lock_addr", mem_addr, 64'h2000);
    chk("s3_lock_wren", mem_wren, 0);
    tick(); mem_ready = 1; look();
    tick(); mem_ready = 0; dc_rden = 0; look();
    chk("s3_bubble", mem_rden, 0);
    tick(); look();
    chk("s3_ic_after", mem_addr, 64'h1040);
    tick(); mem_ready = 1; look();
    tick(); mem_ready = 0; ic_rden = 0; look();
    // icache pulse during busy dcache grant, then dcache withdraws
    tick(); dc_rden = 1; dc_addr = 64'h5000; look();
    tick(); ic_rden = 1; ic_addr = 64'h6000; look();
    chk("s4_addr", mem_addr, 64'h5000);
    tick(); ic_rden = 0; look();
    tick(); dc_rden = 0; look();
    chk("s4_withdraw", mem_rden, 0);
    tick(); look();
    chk("s4_idle", mem_addr, 0);
    // watchdog
    tick(); dc_rden = 1; dc_addr = 64'h7000; look();
    for (int k = 1; k <= 6; k++) begin
      tick(); look();
      chk($sformatf("s5_to%0d", k), mem_timeout, k == 4);
    end
    chk("s5_hold", mem_rden, 1);
    tick(); mem_ready = 1; look();
    chk("s5_done", dc_ready, 1);
    tick(); mem_ready = 0; dc_rden = 0; look();
    // reset in the middle of an icache grant
    tick(); ic_rden = 1; ic_addr = 64'h8000; look();
    tick(); dc_rden = 1; dc_addr = 64'h9000; look();
    chk("s6_gnt_ic", mem_addr, 64'h8000);
    tick(); #2 rst = 1; mem_ready = 1; #1;
    chk("s6_rst_rden", mem_rden, 0);
    chk("s6_rst_icready", ic_ready, 0);
    chk("s6_rst_dcready", dc_ready, 0);
    look();
    tick(); rst = 0; mem_ready = 0; look();
    tick(); look();
    chk("s6_dc_wins", mem_addr, 64'h9000);
    tick(); mem_ready = 1; look();
    tick(); mem_ready = 0; dc_rden = 0; ic_rden = 0; look();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
